// File: rtl/apb_master_arbiter.sv
// Round-robin APB master shared by NUM_REQ requesters.
// Sequences APB SETUP/ACCESS phases, honours PREADY wait states and returns
// read data plus a one-cycle completion pulse to the granted requester.
// Optional feature: define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT
// consecutive cycles with PREADY low (completion with rsp_err = 1).
module apb_master_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [ADDR_W-1:0]         PADDR,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic [31:0]               PWDATA,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [IdxW-1:0]     grant_q, grant_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [31:0]         pwdata_q, pwdata_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                busy_q, busy_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [NUM_REQ-1:0]  arb_mask;
    logic                arb_any;
    logic [IdxW-1:0]     arb_idx;
    logic [IdxW-1:0]     cand;
    logic                load;
    logic                abort;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0]     cnt_q, cnt_d;
`endif

    // Round-robin pick: first asserted request at or after the pointer.
    // The request being completed this cycle is masked so it cannot win again.
    always_comb begin
        arb_mask = req_valid;
        if (state_q == StAccess) begin
            arb_mask[grant_q] = 1'b0;
        end
        arb_any = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IdxW'((32'(ptr_q) + 32'(k)) % NUM_REQ);
            if (!arb_any && arb_mask[cand]) begin
                arb_any = 1'b1;
                arb_idx = cand;
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/SETUP/ACCESS FSM.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        done_d   = '0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        load     = 1'b0;
        abort    = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (arb_any) begin
                    state_d = StSetup;
                    load    = 1'b1;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
`ifdef APB_ARB_TIMEOUT_EN
                // Abort on the cycle that would bring the stall count to TIMEOUT.
                abort = !PREADY && (32'(cnt_q) == TIMEOUT - 1);
                if (!PREADY) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
                if (PREADY || abort) begin
                    done_d[grant_q] = 1'b1;
                    rdata_d         = (pwrite_q || abort) ? 32'h0 : PRDATA;
                    err_d           = abort;
                    if (arb_any) begin
                        state_d = StSetup;
                        load    = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Bus fields only change on entry to SETUP.
        if (load) begin
            grant_d  = arb_idx;
            ptr_d    = (32'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
            paddr_d  = req_addr[32'(arb_idx)*ADDR_W +: ADDR_W];
            pwrite_d = req_write[arb_idx];
            pwdata_d = req_wdata[32'(arb_idx)*32 +: 32];
`ifdef APB_ARB_TIMEOUT_EN
            cnt_d    = '0;
`endif
        end

        psel_d    = (state_d != StIdle);
        penable_d = (state_d == StAccess);
        busy_d    = psel_d;
    end

    // State and output registers; asynchronous reset clears everything.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            grant_q   <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    // Count consecutive ACCESS cycles with PREADY low.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign busy      = busy_q;
    assign req_done  = done_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
